// File: rtl/infra_pkg.sv
// rtl/infra_pkg.sv - shared types and helpers for the reset sequencer
// Purpose: FSM state encoding, loss-counter width and a saturating increment.
package infra_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/infra_reset_seq_if.sv
// rtl/infra_reset_seq_if.sv - signal bundle between the sequencer and its environment
// Purpose: groups the sequencer's status inputs and reset/status outputs.
// Ports (slave = sequencer side):
//   in : pub, pll_lock, rtc_tick (asynchronous), soft_reset (synchronous pulse)
//   out: domain_rst[NUM_DOMAINS], fpgagood, rtc_alive, state[3], lock_loss_count[8]
interface infra_reset_seq_if #(
  parameter int NUM_DOMAINS = 3
);
  import infra_pkg::*;

  logic                   pub;
  logic                   pll_lock;
  logic                   rtc_tick;
  logic                   soft_reset;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   fpgagood;
  logic                   rtc_alive;
  logic [2:0]             state;
  logic [LOSS_CNT_W-1:0]  lock_loss_count;

  modport master (
    output pub, pll_lock, rtc_tick, soft_reset,
    input  domain_rst, fpgagood, rtc_alive, state, lock_loss_count
  );

  modport slave (
    input  pub, pll_lock, rtc_tick, soft_reset,
    output domain_rst, fpgagood, rtc_alive, state, lock_loss_count
  );

endinterface

// File: rtl/infra_sync.sv
// rtl/infra_sync.sv - two-flop synchroniser, parametrised width
// Purpose: brings asynchronous level inputs into the clk domain.
// Ports: clk, rst_n (async active-low, clears to 0), d[WIDTH] in, q[WIDTH] out.
module infra_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/infra_reset_seq.sv
// rtl/infra_reset_seq.sv - power-good / PLL-lock reset sequencer with staggered release
// Purpose: waits for power-good and a stable PLL lock, releases NUM_DOMAINS resets
//   one by one, re-sequences on lock loss / power loss / soft reset, reports fpgagood.
// Ports: gclk (always-on clock), reset_n (async active-low), bus (infra_reset_seq_if.slave).
// Build option: define INFRA_RTC_WDOG_EN to add the RTC activity watchdog; otherwise
//   rtc_alive is 1 after reset and fpgagood depends only on the RUN state.
module infra_reset_seq
  import infra_pkg::*;
#(
  parameter int NUM_DOMAINS        = 3,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int FAULT_HOLD_CYCLES  = 256,
  parameter int RTC_TIMEOUT        = 4096
) (
  input  logic             gclk,
  input  logic             reset_n,
  infra_reset_seq_if.slave bus
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int GW = $clog2(STAGGER_CYCLES) + 1;
  localparam int FW = $clog2(FAULT_HOLD_CYCLES) + 1;

  localparam logic [SW-1:0]          STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0]          STAGGER_LAST = GW'(STAGGER_CYCLES - 1);
  localparam logic [FW-1:0]          FAULT_LAST   = FW'(FAULT_HOLD_CYCLES - 1);
  localparam logic [2:0]             IDX_LAST     = 3'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE      = NUM_DOMAINS'(1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL      = '1;

  logic [1:0] lvl_s;
  logic       pub_s;
  logic       lock_s;

  infra_sync #(.WIDTH(2)) u_sync_lvl (
    .clk   (gclk),
    .rst_n (reset_n),
    .d     ({bus.pub, bus.pll_lock}),
    .q     (lvl_s)
  );

  assign pub_s  = lvl_s[1];
  assign lock_s = lvl_s[0];

  state_t                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic [2:0]             idx_q, idx_d;
  logic [SW-1:0]          stable_cnt_q, stable_cnt_d;
  logic [GW-1:0]          stagger_cnt_q, stagger_cnt_d;
  logic [FW-1:0]          fault_cnt_q, fault_cnt_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic                   fpgagood_q, fpgagood_d;
  logic                   rtc_alive_q, rtc_alive_d;

  // Counters default to 0 each cycle, so only the counter of the current state
  // advances and every state entry starts from a cleared count.
  always_comb begin
    state_d       = state_q;
    domain_rst_d  = domain_rst_q;
    idx_d         = idx_q;
    stable_cnt_d  = '0;
    stagger_cnt_d = '0;
    fault_cnt_d   = '0;
    loss_cnt_d    = loss_cnt_q;

    if (!pub_s) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_LOCK;
        WAIT_LOCK: if (lock_s) state_d = STABLE;
        STABLE: begin
          if (!lock_s || bus.soft_reset) begin
            state_d = WAIT_LOCK;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_d      = RELEASE;
            idx_d        = '0;
            domain_rst_d = DOM_ALL & ~DOM_ONE;
          end else begin
            stable_cnt_d = stable_cnt_q + SW'(1);
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = FAULT;
          end else if (bus.soft_reset) begin
            state_d = WAIT_LOCK;
          end else if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else if (stagger_cnt_q == STAGGER_LAST) begin
            idx_d        = idx_q + 3'd1;
            domain_rst_d = domain_rst_q & ~(DOM_ONE << (idx_q + 3'd1));
          end else begin
            stagger_cnt_d = stagger_cnt_q + GW'(1);
          end
        end
        RUN: begin
          if (!lock_s)              state_d = FAULT;
          else if (bus.soft_reset)  state_d = WAIT_LOCK;
        end
        FAULT: begin
          if (fault_cnt_q == FAULT_LAST) state_d = WAIT_LOCK;
          else                           fault_cnt_d = fault_cnt_q + FW'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    // Any exit from RELEASE/RUN re-asserts every domain in the same cycle.
    if (state_d != RELEASE && state_d != RUN) begin
      domain_rst_d = DOM_ALL;
      idx_d        = '0;
    end

    if (state_d == FAULT && state_q != FAULT) loss_cnt_d = sat_inc(loss_cnt_q);

    fpgagood_d = (state_q == RUN) && rtc_alive_q;
  end

`ifdef INFRA_RTC_WDOG_EN
  localparam int            WW       = $clog2(RTC_TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_MAX = WW'(RTC_TIMEOUT);

  logic          rtc_s;
  logic          rtc_rise;
  logic          rtc_prev_q, rtc_prev_d;
  logic [WW-1:0] wdog_q, wdog_d;

  infra_sync #(.WIDTH(1)) u_sync_rtc (
    .clk   (gclk),
    .rst_n (reset_n),
    .d     (bus.rtc_tick),
    .q     (rtc_s)
  );

  assign rtc_rise = rtc_s & ~rtc_prev_q;

  always_comb begin
    rtc_prev_d = rtc_s;
    if (rtc_rise)               wdog_d = '0;
    else if (wdog_q == WDOG_MAX) wdog_d = wdog_q;
    else                        wdog_d = wdog_q + WW'(1);
    // Alive is held from the cycle after an edge until the watchdog saturates.
    if (rtc_rise)                rtc_alive_d = 1'b1;
    else if (wdog_d == WDOG_MAX) rtc_alive_d = 1'b0;
    else                         rtc_alive_d = rtc_alive_q;
  end

  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      rtc_prev_q <= 1'b0;
      wdog_q     <= '0;
    end else begin
      rtc_prev_q <= rtc_prev_d;
      wdog_q     <= wdog_d;
    end
  end
`else
  logic unused_rtc_tick;
  assign unused_rtc_tick = bus.rtc_tick;
  assign rtc_alive_d     = 1'b1;
`endif

  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      domain_rst_q  <= DOM_ALL;
      idx_q         <= '0;
      stable_cnt_q  <= '0;
      stagger_cnt_q <= '0;
      fault_cnt_q   <= '0;
      loss_cnt_q    <= '0;
      fpgagood_q    <= 1'b0;
      rtc_alive_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      domain_rst_q  <= domain_rst_d;
      idx_q         <= idx_d;
      stable_cnt_q  <= stable_cnt_d;
      stagger_cnt_q <= stagger_cnt_d;
      fault_cnt_q   <= fault_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      fpgagood_q    <= fpgagood_d;
      rtc_alive_q   <= rtc_alive_d;
    end
  end

  assign bus.domain_rst      = domain_rst_q;
  assign bus.fpgagood        = fpgagood_q;
  assign bus.rtc_alive       = rtc_alive_q;
  assign bus.state           = state_q;
  assign bus.lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_infra_reset_seq.sv
// tb/tb_infra_reset_seq.sv - directed self-checking bench for infra_reset_seq
`timescale 1ns/1ps
module tb_infra_reset_seq;

  localparam int N = 3;
  localparam int L = 8;
  localparam int S = 4;
  localparam int F = 16;
  localparam int T = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STAB = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_FLT  = 3'd5;

  logic gclk    = 1'b0;
  logic reset_n = 1'b0;
  logic rtc_en  = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;

  infra_reset_seq_if #(.NUM_DOMAINS(N)) bus();

  infra_reset_seq #(
    .NUM_DOMAINS        (N),
    .LOCK_STABLE_CYCLES (L),
    .STAGGER_CYCLES     (S),
    .FAULT_HOLD_CYCLES  (F),
    .RTC_TIMEOUT        (T)
  ) dut (
    .gclk    (gclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 gclk = ~gclk;

  // RTC tick: toggles every 8 cycles while enabled (16-cycle period).
  always begin
    repeat (8) @(negedge gclk);
    if (rtc_en) bus.rtc_tick = ~bus.rtc_tick;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
    $fatal(1);
  end

  // Reset release happens at a negedge; cyc = k means k rising edges since release.
  task automatic do_reset();
    reset_n        = 1'b0;
    bus.pub        = 1'b1;
    bus.pll_lock   = 1'b1;
    bus.soft_reset = 1'b0;
    repeat (3) @(negedge gclk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) begin
      @(negedge gclk);
      cyc++;
    end
  endtask

  function automatic logic [6:0] cold_exp(input int k);
    logic [2:0] st;
    logic [2:0] r;
    logic       g;
    st = (k <= 2) ? S_IDLE : (k == 3) ? S_WAIT : (k <= 11) ? S_STAB : (k <= 20) ? S_REL : S_RUN;
    r  = (k <= 11) ? 3'b111 : (k <= 15) ? 3'b110 : (k <= 19) ? 3'b100 : 3'b000;
    g  = (k >= 22);
    return {st, r, g};
  endfunction

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.pub        = 1'b0;
    bus.pll_lock   = 1'b0;
    bus.soft_reset = 1'b0;
    repeat (2) @(negedge gclk);
    checks++; if (bus.domain_rst !== 3'b111) begin errors++; $display("FAIL reset_domain_rst: got %b want 111", bus.domain_rst); end
    checks++; if (bus.fpgagood !== 1'b0) begin errors++; $display("FAIL reset_fpgagood: got %b want 0", bus.fpgagood); end
    checks++; if (bus.rtc_alive !== 1'b0) begin errors++; $display("FAIL reset_rtc_alive: got %b want 0", bus.rtc_alive); end
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_llc: got %0d want 0", bus.lock_loss_count); end
  endtask

  task automatic test_cold_start();
    logic [6:0] obs;
    logic [6:0] exp;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      step_to(k);
      obs = {bus.state, bus.domain_rst, bus.fpgagood};
      exp = cold_exp(k);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cold_start cyc%0d: got st=%0d rst=%b good=%b want st=%0d rst=%b good=%b",
                 k, obs[6:4], obs[3:1], obs[0], exp[6:4], exp[3:1], exp[0]);
      end
    end
  endtask

  task automatic test_lock_glitch();
    do_reset();
    step_to(9);  bus.pll_lock = 1'b0;
    step_to(10); bus.pll_lock = 1'b1;
    step_to(11);
    checks++; if (bus.state !== S_STAB) begin errors++; $display("FAIL glitch_still_stable: got %0d want 2", bus.state); end
    step_to(12);
    checks++; if (bus.state !== S_WAIT) begin errors++; $display("FAIL glitch_wait_lock: got %0d want 1", bus.state); end
    step_to(13);
    checks++; if (bus.state !== S_STAB) begin errors++; $display("FAIL glitch_restable: got %0d want 2", bus.state); end
    step_to(20);
    checks++; if ({bus.state, bus.domain_rst} !== {S_STAB, 3'b111}) begin errors++; $display("FAIL glitch_count_restart: got st=%0d rst=%b want st=2 rst=111", bus.state, bus.domain_rst); end
    step_to(21);
    checks++; if ({bus.state, bus.domain_rst} !== {S_REL, 3'b110}) begin errors++; $display("FAIL glitch_release: got st=%0d rst=%b want st=3 rst=110", bus.state, bus.domain_rst); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL glitch_llc: got %0d want 0", bus.lock_loss_count); end
  endtask

  task automatic test_lock_loss_run();
    do_reset();
    step_to(25); bus.pll_lock = 1'b0;
    step_to(27);
    checks++; if ({bus.state, bus.domain_rst} !== {S_RUN, 3'b000}) begin errors++; $display("FAIL loss_before: got st=%0d rst=%b want st=4 rst=000", bus.state, bus.domain_rst); end
    step_to(28);
    checks++; if ({bus.state, bus.domain_rst, bus.fpgagood} !== {S_FLT, 3'b111, 1'b1}) begin errors++; $display("FAIL loss_fault_entry: got st=%0d rst=%b good=%b want st=5 rst=111 good=1", bus.state, bus.domain_rst, bus.fpgagood); end
    checks++; if (bus.lock_loss_count !== 8'd1) begin errors++; $display("FAIL loss_llc: got %0d want 1", bus.lock_loss_count); end
    step_to(29);
    checks++; if (bus.fpgagood !== 1'b0) begin errors++; $display("FAIL loss_fpgagood: got %b want 0", bus.fpgagood); end
    step_to(43);
    checks++; if (bus.state !== S_FLT) begin errors++; $display("FAIL loss_fault_hold: got %0d want 5", bus.state); end
    step_to(44);
    checks++; if (bus.state !== S_WAIT) begin errors++; $display("FAIL loss_fault_exit: got %0d want 1", bus.state); end
    bus.pll_lock = 1'b1;
    step_to(46);
    checks++; if (bus.state !== S_WAIT) begin errors++; $display("FAIL loss_wait_sync: got %0d want 1", bus.state); end
    step_to(47);
    checks++; if (bus.state !== S_STAB) begin errors++; $display("FAIL loss_restable: got %0d want 2", bus.state); end
    step_to(55);
    checks++; if ({bus.state, bus.domain_rst} !== {S_REL, 3'b110}) begin errors++; $display("FAIL loss_rerelease: got st=%0d rst=%b want st=3 rst=110", bus.state, bus.domain_rst); end
    step_to(65);
    checks++; if ({bus.state, bus.domain_rst, bus.fpgagood} !== {S_RUN, 3'b000, 1'b1}) begin errors++; $display("FAIL loss_rerun: got st=%0d rst=%b good=%b want st=4 rst=000 good=1", bus.state, bus.domain_rst, bus.fpgagood); end
  endtask

  task automatic test_soft_reset();
    do_reset();
    step_to(25); bus.soft_reset = 1'b1;
    step_to(26); bus.soft_reset = 1'b0;
    checks++; if ({bus.state, bus.domain_rst} !== {S_WAIT, 3'b111}) begin errors++; $display("FAIL soft_wait: got st=%0d rst=%b want st=1 rst=111", bus.state, bus.domain_rst); end
    step_to(27);
    checks++; if ({bus.state, bus.fpgagood, bus.lock_loss_count} !== {S_STAB, 1'b0, 8'd0}) begin errors++; $display("FAIL soft_after: got st=%0d good=%b llc=%0d want st=2 good=0 llc=0", bus.state, bus.fpgagood, bus.lock_loss_count); end
  endtask

  task automatic test_coincident();
    do_reset();
    step_to(25); bus.pll_lock = 1'b0;
    step_to(27); bus.soft_reset = 1'b1;
    checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL coin_before: got %0d want 4", bus.state); end
    step_to(28); bus.soft_reset = 1'b0;
    checks++; if ({bus.state, bus.lock_loss_count} !== {S_FLT, 8'd1}) begin errors++; $display("FAIL coin_fault_wins: got st=%0d llc=%0d want st=5 llc=1", bus.state, bus.lock_loss_count); end
    step_to(30); bus.pub = 1'b0;
    step_to(32);
    checks++; if (bus.state !== S_FLT) begin errors++; $display("FAIL coin_pub_sync: got %0d want 5", bus.state); end
    step_to(33);
    checks++; if ({bus.state, bus.domain_rst} !== {S_IDLE, 3'b111}) begin errors++; $display("FAIL coin_pub_idle: got st=%0d rst=%b want st=0 rst=111", bus.state, bus.domain_rst); end
  endtask

  task automatic test_rtc_stall();
    do_reset();
    step_to(30);
    rtc_en       = 1'b0;
    bus.rtc_tick = 1'b0;
`ifdef INFRA_RTC_WDOG_EN
    step_to(40); bus.rtc_tick = 1'b1;
    step_to(74);
    checks++; if ({bus.rtc_alive, bus.fpgagood} !== 2'b11) begin errors++; $display("FAIL rtc_alive_hold: got alive=%b good=%b want 11", bus.rtc_alive, bus.fpgagood); end
    step_to(75);
    checks++; if ({bus.rtc_alive, bus.fpgagood} !== 2'b01) begin errors++; $display("FAIL rtc_alive_drop: got alive=%b good=%b want alive=0 good=1", bus.rtc_alive, bus.fpgagood); end
    step_to(76);
    checks++; if ({bus.fpgagood, bus.domain_rst, bus.state} !== {1'b0, 3'b000, S_RUN}) begin errors++; $display("FAIL rtc_good_drop: got good=%b rst=%b st=%0d want good=0 rst=000 st=4", bus.fpgagood, bus.domain_rst, bus.state); end
    step_to(80); bus.rtc_tick = 1'b0;
    step_to(90); bus.rtc_tick = 1'b1;
    step_to(92);
    checks++; if (bus.rtc_alive !== 1'b0) begin errors++; $display("FAIL rtc_still_dead: got %b want 0", bus.rtc_alive); end
    step_to(93);
    checks++; if ({bus.rtc_alive, bus.fpgagood} !== 2'b10) begin errors++; $display("FAIL rtc_recover_alive: got alive=%b good=%b want alive=1 good=0", bus.rtc_alive, bus.fpgagood); end
    step_to(94);
    checks++; if ({bus.rtc_alive, bus.fpgagood} !== 2'b11) begin errors++; $display("FAIL rtc_recover_good: got alive=%b good=%b want 11", bus.rtc_alive, bus.fpgagood); end
`else
    step_to(90);
    checks++; if ({bus.rtc_alive, bus.fpgagood, bus.state} !== {2'b11, S_RUN}) begin errors++; $display("FAIL rtc_nowdog: got alive=%b good=%b st=%0d want 1 1 4", bus.rtc_alive, bus.fpgagood, bus.state); end
`endif
    rtc_en = 1'b1;
  endtask

  task automatic test_saturation();
    int  n;
    logic timed_out;
    timed_out = 1'b0;
    do_reset();
    for (int i = 0; i < 300 && !timed_out; i++) begin
      n = 0;
      while (bus.state !== S_REL && n < 200) begin @(negedge gclk); n++; end
      if (n >= 200) timed_out = 1'b1;
      bus.pll_lock = 1'b0;
      n = 0;
      while (bus.state !== S_WAIT && n < 200) begin @(negedge gclk); n++; end
      if (n >= 200) timed_out = 1'b1;
      bus.pll_lock = 1'b1;
      if (i == 99) begin
        checks++; if (bus.lock_loss_count !== 8'd100) begin errors++; $display("FAIL sat_llc_100: got %0d want 100", bus.lock_loss_count); end
      end
    end
    checks++; if (timed_out) begin errors++; $display("FAIL sat_timeout: state stuck at %0d, required progress within 200 cycles", bus.state); end
    checks++; if (bus.lock_loss_count !== 8'd255) begin errors++; $display("FAIL sat_llc_255: got %0d want 255", bus.lock_loss_count); end
  endtask

  task automatic test_reset_mid_release();
    int n;
    n = 0;
    while (bus.state !== S_REL && n < 200) begin @(negedge gclk); n++; end
    @(negedge gclk);
    checks++; if ({bus.state, bus.domain_rst} !== {S_REL, 3'b110}) begin errors++; $display("FAIL midrel_before: got st=%0d rst=%b want st=3 rst=110", bus.state, bus.domain_rst); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.state, bus.domain_rst, bus.fpgagood, bus.rtc_alive} !== {S_IDLE, 3'b111, 2'b00}) begin errors++; $display("FAIL midrel_async: got st=%0d rst=%b good=%b alive=%b want st=0 rst=111 good=0 alive=0", bus.state, bus.domain_rst, bus.fpgagood, bus.rtc_alive); end
    checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL midrel_llc: got %0d want 0", bus.lock_loss_count); end
    @(negedge gclk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.pub        = 1'b0;
    bus.pll_lock   = 1'b0;
    bus.rtc_tick   = 1'b0;
    bus.soft_reset = 1'b0;
    test_reset();
    test_cold_start();
    test_lock_glitch();
    test_lock_loss_run();
    test_soft_reset();
    test_coincident();
    test_rtc_stall();
    test_saturation();
    test_reset_mid_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/infra_reset_seq.md
# infra_reset_seq

Parametrised clock/power-good reset sequencer that supersedes fixed single-shot infrastructure bring-up. It watches power-up-good, PLL lock and RTC tick activity, then releases NUM_DOMAINS per-domain resets in a staggered order. It re-sequences on lock loss, power loss or soft reset, and drives an aggregated FPGAGOOD indication. It sits beside the clock generators at the top of the monitor design and runs on the slow always-on global clock.

## Interface
Parameters:
- NUM_DOMAINS, 3, number of downstream reset domains (1..8)
- LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release
- STAGGER_CYCLES, 16, spacing between successive domain releases
- FAULT_HOLD_CYCLES, 256, minimum time held in FAULT
- RTC_TIMEOUT, 4096, cycles without an RTC tick before rtc_alive drops

Ports:
- gclk  in  1  sequencer clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pub  in  1  power-up-good, asynchronous, synchronised internally
- pll_lock  in  1  PLL lock, asynchronous, synchronised internally
- rtc_tick  in  1  RTC-derived clock or tick, asynchronous, rising edges counted
- soft_reset  in  1  synchronous single-cycle request to re-sequence
- domain_rst  out  NUM_DOMAINS  active-high resets; bit 0 is released first
- fpgagood  out  1  system good
- rtc_alive  out  1  RTC activity seen within RTC_TIMEOUT
- state  out  3  current FSM state encoding
- lock_loss_count  out  8  saturating count of FAULT entries

## Operation
- Synchronisers: pub, pll_lock and rtc_tick each pass through 2 flops. rtc_tick then gets a rising-edge detect (third flop).
- States:
  - IDLE: all domain_rst=1. Go to WAIT_LOCK when synced pub=1.
  - WAIT_LOCK: go to STABLE when synced lock=1.
  - STABLE: counts consecutive lock cycles. If lock drops, clear the count and return to WAIT_LOCK; this does not increment lock_loss_count. After LOCK_STABLE_CYCLES cycles, go to RELEASE.
  - RELEASE: index i starts at 0. Deassert domain_rst[i], then wait STAGGER_CYCLES and increment i. One cycle after the last domain is released, go to RUN.
  - RUN: steady operation.
  - FAULT: set all domain_rst=1. Increment lock_loss_count on entry, saturating at 255. Hold FAULT_HOLD_CYCLES cycles, then go to WAIT_LOCK.
- Lock loss in RELEASE or RUN goes to FAULT.
- soft_reset in STABLE, RELEASE or RUN: set all domain_rst=1 and go to WAIT_LOCK. No count.
- Synced pub=0 in any state: go to IDLE with all domain_rst=1. This overrides everything.
- Priority when events coincide: pub loss > lock loss > soft_reset.
- A released domain_rst bit never reasserts except on leaving RELEASE/RUN; all bits reassert together in the same cycle.
- fpgagood is registered: 1 iff state==RUN and rtc_alive (see Configuration).
- Counter widths are $clog2 of their parameter plus 1. The stable, stagger and fault counters all clear on every state entry.

## Timing
- Reset values: domain_rst all 1, fpgagood 0, rtc_alive 0, state IDLE (0), lock_loss_count 0, all counters 0.
- reset_n asserted mid-sequence returns to the reset values immediately (asynchronous).
- Latency from pub and pll_lock edges to FSM reaction is 2 cycles.
- With pub and lock already high, domain_rst[0] falls 2+1+1+LOCK_STABLE_CYCLES cycles after reset_n deasserts.
- domain_rst[i] falls STAGGER_CYCLES·i cycles after domain_rst[0].
- fpgagood rises 1 cycle after state enters RUN and falls 1 cycle after state leaves RUN.
- All domain_rst bits reassert in the cycle the FSM leaves RELEASE/RUN. This is 2 cycles after the async lock/pub edge, or 1 cycle after soft_reset.

## Configuration
- INFRA_RTC_WDOG_EN defined:
  - A watchdog counter increments each cycle and saturates at RTC_TIMEOUT.
  - It clears on each synced rtc_tick rising edge.
  - rtc_alive=1 from the cycle after an edge until the counter reaches RTC_TIMEOUT.
  - fpgagood requires rtc_alive.
- INFRA_RTC_WDOG_EN undefined:
  - No rtc_tick synchroniser or watchdog logic.
  - rtc_alive is tied to 1 after reset.
  - fpgagood depends only on state==RUN.

## Structure
- Shared package infra_pkg holds:
  - state typedef: IDLE=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5
  - LOSS_CNT_W=8
- Sub-module infra_sync: parametrised-width 2-flop synchroniser with async active-low reset to 0. It is instantiated for {pub, pll_lock} and, under the macro, for rtc_tick.

## Test plan
Bench parameters: NUM_DOMAINS=3, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, FAULT_HOLD_CYCLES=16, RTC_TIMEOUT=32, macro defined, rtc_tick toggling every 8 cycles.

- Cold start:
  - Stimulus: pub=1 and pll_lock=1 from reset release.
  - Required: domain_rst=111→110→100→000 at 4-cycle spacing, then fpgagood=1 one cycle after state=RUN.
- Lock glitch in STABLE:
  - Stimulus: drop lock for 1 cycle at stable count 5.
  - Required: return to WAIT_LOCK, the count restarts, lock_loss_count stays 0.
- Lock loss in RUN:
  - Stimulus: pll_lock=0 while in RUN.
  - Required: domain_rst=111 2 cycles later, fpgagood=0, lock_loss_count=1, FAULT lasts 16 cycles, then re-sequence once lock returns.
- Coincident events:
  - Stimulus: soft_reset and lock loss in the same cycle.
  - Required: FAULT wins and the count increments. Separately, pub=0 in FAULT goes straight to IDLE.
- RTC stall:
  - Stimulus: stop rtc_tick in RUN.
  - Required: rtc_alive and fpgagood drop 32 cycles after the last edge while domain_rst stays 000; both recover 1 cycle after the next edge.
- Saturation:
  - Stimulus: 300 forced lock losses.
  - Required: lock_loss_count=255.
  - Also: reset_n pulse mid-RELEASE restores all reset values.
